// File: rtl/tsq_pkg.sv
// Shared constants and types for the PTP timestamp-queue reader.
package tsq_pkg;

  // Register block byte addresses
  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STAT    = 8'h04;
  localparam logic [7:0] ADDR_RXTS_HI = 8'h50;
  localparam logic [7:0] ADDR_RXTS_LO = 8'h54;
  localparam logic [7:0] ADDR_TXTS_HI = 8'h58;
  localparam logic [7:0] ADDR_TXTS_LO = 8'h5C;

  // Control register read-enable bits; the block owns bits 11:8
  localparam int          RXQ_RD       = 10;
  localparam int          TXQ_RD       = 8;
  localparam logic [31:0] CTRL_RD_MASK = 32'h0000_0F00;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_STAT,
    ST_CHK,
    ST_RD_HI,
    ST_RD_LO,
    ST_CAP,
    ST_POP_SET,
    ST_POP_CLR,
    ST_SETTLE
  } tsq_state_e;

  // Control word with the block-owned bits replaced: all clear, or one pop bit set
  function automatic logic [31:0] ctrl_word(input logic [31:0] base,
                                            input logic        pop,
                                            input logic        tx);
    logic [31:0] w;
    w = base & ~CTRL_RD_MASK;
    if (pop && tx)
      w[TXQ_RD] = 1'b1;
    else if (pop)
      w[RXQ_RD] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/tsq_out_slot.sv
// Single-entry valid/ready holding register for one timestamp and its direction.
module tsq_out_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        load_dir,
  input  logic [55:0] load_data,
  input  logic        ready,
  output logic        valid,
  output logic        dir,
  output logic [55:0] data
);

  // A new load takes priority over a same-cycle hand-off; payload holds while valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dir   <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dir   <= load_dir;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tsq_reader.sv
// Register-bus initiator that drains the RX/TX timestamp queues into a stream.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_INIT    | issue one control write clearing bits 11:8 (queues a write)
// ST_IDLE    | poll timer runs while enabled; leaves only when slot is empty
// ST_RD_STAT | status read strobe on the bus
// ST_CHK     | status data returned; pick a queue or go back to idle
// ST_RD_HI   | high timestamp word read strobe
// ST_RD_LO   | low word read strobe; high word data returned
// ST_CAP     | low word data returned; slot loaded
// ST_POP_SET | control write with the selected read-enable bit set
// ST_POP_CLR | control write with bits 11:8 cleared
// ST_SETTLE  | let the pop propagate through the register block
module tsq_reader
  import tsq_pkg::*;
#(
  parameter int POLL_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [31:0] ctrl_base_in,
  output logic        wr_out,
  output logic        rd_out,
  output logic [7:0]  addr_out,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic        ts_valid_out,
  input  logic        ts_ready_in,
  output logic        ts_dir_out,
  output logic [55:0] ts_data_out,
  output logic        busy_out
);

  // Poll timer counts down to zero; zero is "expired". Settle timer reload
  // accounts for the single idle cycle spent before the next status read.
  localparam logic [7:0] POLL_RELOAD   = 8'(POLL_CYCLES - 1);
  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 2);

  tsq_state_e  state;
  logic [7:0]  poll_cnt;
  logic [7:0]  settle_cnt;
  logic        rr_tx;
  logic        sel_tx;
  logic [23:0] ts_hi;
  logic        rx_ne;
  logic        tx_ne;
  logic        pick_tx;
  logic        cap_load;

  assign rx_ne    = |data_in[23:16];
  assign tx_ne    = |data_in[7:0];
  assign pick_tx  = (rx_ne && tx_ne) ? rr_tx : tx_ne;
  assign cap_load = (state == ST_CAP);

  // Sequencer: bus strobes are registered together with the state they belong to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT;
      poll_cnt   <= '0;
      settle_cnt <= '0;
      rr_tx      <= 1'b0;
      sel_tx     <= 1'b0;
      ts_hi      <= '0;
      wr_out     <= 1'b0;
      rd_out     <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
      busy_out   <= 1'b0;
    end else begin
      wr_out   <= 1'b0;
      rd_out   <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
      case (state)
        ST_INIT: begin
          wr_out   <= 1'b1;
          addr_out <= ADDR_CTRL;
          data_out <= ctrl_word(ctrl_base_in, 1'b0, 1'b0);
          state    <= ST_IDLE;
        end
        ST_IDLE: begin
          if (enable_in) begin
            if (poll_cnt != '0) begin
              poll_cnt <= poll_cnt - 8'd1;
            end else if (!ts_valid_out) begin
              rd_out   <= 1'b1;
              addr_out <= ADDR_STAT;
              busy_out <= 1'b1;
              state    <= ST_RD_STAT;
            end
          end
        end
        ST_RD_STAT: begin
          state <= ST_CHK;
        end
        ST_CHK: begin
          if (!rx_ne && !tx_ne) begin
            poll_cnt <= POLL_RELOAD;
            busy_out <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            sel_tx   <= pick_tx;
            if (rx_ne && tx_ne)
              rr_tx <= ~rr_tx;
            rd_out   <= 1'b1;
            addr_out <= pick_tx ? ADDR_TXTS_HI : ADDR_RXTS_HI;
            state    <= ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          rd_out   <= 1'b1;
          addr_out <= sel_tx ? ADDR_TXTS_LO : ADDR_RXTS_LO;
          state    <= ST_RD_LO;
        end
        ST_RD_LO: begin
          ts_hi <= data_in[23:0];
          state <= ST_CAP;
        end
        ST_CAP: begin
          wr_out   <= 1'b1;
          addr_out <= ADDR_CTRL;
          data_out <= ctrl_word(ctrl_base_in, 1'b1, sel_tx);
          state    <= ST_POP_SET;
        end
        ST_POP_SET: begin
          wr_out   <= 1'b1;
          addr_out <= ADDR_CTRL;
          data_out <= ctrl_word(ctrl_base_in, 1'b0, sel_tx);
          state    <= ST_POP_CLR;
        end
        ST_POP_CLR: begin
          settle_cnt <= SETTLE_RELOAD;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            poll_cnt <= '0;
            busy_out <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  tsq_out_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (cap_load),
    .load_dir  (sel_tx),
    .load_data ({ts_hi, data_in}),
    .ready     (ts_ready_in),
    .valid     (ts_valid_out),
    .dir       (ts_dir_out),
    .data      (ts_data_out)
  );

endmodule

// File: tb/tb_tsq_reader.sv
// Bench for tsq_reader: register-block model with RX/TX queues plus a stream scoreboard.
module tb_tsq_reader;

  localparam int P = 16;
  localparam int S = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_in = 1'b0;
  logic [31:0] ctrl_base_in = '0;
  logic [31:0] data_in = '0;
  logic        ts_ready_in = 1'b0;
  logic        wr_out, rd_out, ts_valid_out, ts_dir_out, busy_out;
  logic [7:0]  addr_out;
  logic [31:0] data_out;
  logic [55:0] ts_data_out;

  always #5 clk = ~clk;

  tsq_reader #(.POLL_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_in    (enable_in),
    .ctrl_base_in (ctrl_base_in),
    .wr_out       (wr_out),
    .rd_out       (rd_out),
    .addr_out     (addr_out),
    .data_out     (data_out),
    .data_in      (data_in),
    .ts_valid_out (ts_valid_out),
    .ts_ready_in  (ts_ready_in),
    .ts_dir_out   (ts_dir_out),
    .ts_data_out  (ts_data_out),
    .busy_out     (busy_out)
  );

  typedef struct {
    int          cyc;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t         ev_q[$];
  logic [63:0] rxq[$];
  logic [63:0] txq[$];
  logic [56:0] exp_q[$];
  logic [56:0] got_q[$];
  int          checks = 0;
  int          failures = 0;
  int          viol = 0;
  int          cyc = 0;
  bit          m_rr_tx = 0;
  bit          noise = 0;
  bit          pend_rd = 0;
  logic [7:0]  pend_addr = '0;
  bit          prev_v = 0, prev_r = 0, prev_dir = 0;
  logic [55:0] prev_d = '0;

  function automatic logic [55:0] ts_of(input logic [63:0] e);
    return {e[55:32], e[31:0]};
  endfunction

  function automatic int count_rd04();
    int n = 0;
    foreach (ev_q[i]) if (!ev_q[i].wr && ev_q[i].addr == 8'h04) n++;
    return n;
  endfunction

  function automatic int count_pops();
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].wr && ev_q[i].data[11:8] != 4'h0) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus monitor and queue side effects, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      pend_rd = 0;
      m_rr_tx = 0;
      prev_v  = 0;
      exp_q.delete();
      got_q.delete();
    end else begin
      if (rd_out && wr_out) viol++;
      if (!rd_out && !wr_out && (addr_out != 8'h00 || data_out != 32'h0)) viol++;
      if (rd_out || wr_out) ev_q.push_back('{cyc, wr_out, addr_out, data_out});
      if (wr_out && addr_out != 8'h00) viol++;
      if (wr_out && data_out[10]) begin
        if (rxq.size() > 0) rxq.delete(0); else viol++;
      end
      if (wr_out && data_out[8]) begin
        if (txq.size() > 0) txq.delete(0); else viol++;
      end
      if (prev_v && !prev_r &&
          (!ts_valid_out || ts_data_out !== prev_d || ts_dir_out !== prev_dir)) viol++;
      if (ts_valid_out && ts_ready_in) got_q.push_back({ts_dir_out, ts_data_out});
      prev_v   = ts_valid_out;
      prev_r   = ts_ready_in;
      prev_d   = ts_data_out;
      prev_dir = ts_dir_out;
      pend_rd   = rd_out;
      pend_addr = addr_out;
    end
  end

  // Register block read responder: data valid the cycle after the strobe
  initial forever begin
    int          rxn, txn;
    bit          pick;
    logic [31:0] st;
    @(posedge clk);
    #1;
    if (pend_rd) begin
      case (pend_addr)
        8'h04: begin
          rxn = rxq.size();
          txn = txq.size();
          st = '0;
          st[23:16] = 8'(rxn);
          st[7:0]   = 8'(txn);
          if (noise) begin
            st[31:24] = 8'($urandom);
            st[15:8]  = 8'($urandom);
          end
          if (rxn > 0 || txn > 0) begin
            pick = (rxn > 0 && txn > 0) ? m_rr_tx : (txn > 0);
            if (rxn > 0 && txn > 0) m_rr_tx = !m_rr_tx;
            exp_q.push_back({pick, pick ? ts_of(txq[0]) : ts_of(rxq[0])});
          end
          data_in = st;
        end
        8'h50:   data_in = (rxq.size() > 0) ? rxq[0][63:32] : 32'h0;
        8'h54:   data_in = (rxq.size() > 0) ? rxq[0][31:0]  : 32'h0;
        8'h58:   data_in = (txq.size() > 0) ? txq[0][63:32] : 32'h0;
        8'h5C:   data_in = (txq.size() > 0) ? txq[0][31:0]  : 32'h0;
        default: data_in = 32'h0;
      endcase
    end else begin
      data_in = $urandom;
    end
  end

  task automatic test_reset();
    int n;
    rst = 1'b0; enable_in = 1'b1; ts_ready_in = 1'b1; ctrl_base_in = 32'hA5A5_5FA5;
    repeat (3) step();
    checks++; if (wr_out !== 1'b0) begin failures++; $display("FAIL reset_wr got=%0b exp=0", wr_out); end
    checks++; if (rd_out !== 1'b0) begin failures++; $display("FAIL reset_rd got=%0b exp=0", rd_out); end
    checks++; if (addr_out !== 8'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr_out); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (ts_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ts_valid_out); end
    checks++; if (ts_dir_out !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", ts_dir_out); end
    checks++; if (ts_data_out !== 56'h0) begin failures++; $display("FAIL reset_ts got=%h exp=0", ts_data_out); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_out); end
    ev_q.delete();
    rst = 1'b1;
    n = 0;
    while (ev_q.size() == 0 && n < 8) begin step(); n++; end
    checks++;
    if (ev_q.size() == 0) begin
      failures++; $display("FAIL init_write_timeout got=none exp=write");
    end else if (!ev_q[0].wr || ev_q[0].addr !== 8'h00 || ev_q[0].data !== (ctrl_base_in & ~32'h0F00)) begin
      failures++; $display("FAIL init_write got=wr%0b a=%h d=%h exp=wr1 a=00 d=%h",
                           ev_q[0].wr, ev_q[0].addr, ev_q[0].data, ctrl_base_in & ~32'h0F00);
    end
  endtask

  task automatic test_idle_poll();
    int rc[$];
    int nwr = 0, nother = 0;
    ev_q.delete();
    repeat (5 * (P + 2) + 2) step();
    foreach (ev_q[i]) begin
      if (ev_q[i].wr) nwr++;
      else if (ev_q[i].addr != 8'h04) nother++;
      else rc.push_back(ev_q[i].cyc);
    end
    checks++; if (nwr != 0) begin failures++; $display("FAIL idle_writes got=%0d exp=0", nwr); end
    checks++; if (nother != 0) begin failures++; $display("FAIL idle_other_reads got=%0d exp=0", nother); end
    checks++; if (rc.size() < 4) begin failures++; $display("FAIL idle_poll_count got=%0d exp>=4", rc.size()); end
    for (int i = 1; i < rc.size(); i++) begin
      checks++;
      if (rc[i] - rc[i-1] != P + 2) begin
        failures++; $display("FAIL idle_poll_period got=%0d exp=%0d", rc[i] - rc[i-1], P + 2);
      end
    end
  endtask

  task automatic test_rx_entry();
    logic [7:0]  ra[$];
    logic [31:0] wd[$];
    int n = 0;
    ev_q.delete(); got_q.delete();
    rxq.push_back(64'h00123456_89ABCDEF);
    while (got_q.size() == 0 && n < 4 * P) begin step(); n++; end
    repeat (4) step();
    foreach (ev_q[i]) if (ev_q[i].wr) wd.push_back(ev_q[i].data); else ra.push_back(ev_q[i].addr);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL rx_transfer_count got=%0d exp=1", got_q.size());
    end else if (got_q[0] !== {1'b0, 56'h12345689ABCDEF}) begin
      failures++; $display("FAIL rx_data got=%h exp=%h", got_q[0], {1'b0, 56'h12345689ABCDEF});
    end
    checks++;
    if (ra.size() < 3 || ra[ra.size()-3] !== 8'h04 || ra[ra.size()-2] !== 8'h50 || ra[ra.size()-1] !== 8'h54) begin
      failures++; $display("FAIL rx_read_seq got=%p exp=04,50,54 at end", ra);
    end
    checks++;
    if (wd.size() != 2 || wd[0] !== ((ctrl_base_in & ~32'h0F00) | 32'h400) || wd[1] !== (ctrl_base_in & ~32'h0F00)) begin
      failures++; $display("FAIL rx_pop_writes got=%p exp=set bit10 then clear", wd);
    end
  endtask

  task automatic test_both();
    logic [63:0] r1, r2, t1;
    logic [3:0]  pb[$];
    int n = 0, last_clr = -1, ngap = 0;
    bit prev_pop = 0;
    r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom}; t1 = {$urandom, $urandom};
    ts_ready_in = 1'b1;
    ev_q.delete(); got_q.delete();
    rxq.push_back(r1); rxq.push_back(r2); txq.push_back(t1);
    while (got_q.size() < 3 && n < 300) begin step(); n++; end
    repeat (12) step();
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL both_count got=%0d exp=3", got_q.size());
    end else begin
      checks++; if (got_q[0] !== {1'b0, ts_of(r1)}) begin failures++; $display("FAIL both_first got=%h exp=%h", got_q[0], {1'b0, ts_of(r1)}); end
      checks++; if (got_q[1] !== {1'b1, ts_of(t1)}) begin failures++; $display("FAIL both_second got=%h exp=%h", got_q[1], {1'b1, ts_of(t1)}); end
      checks++; if (got_q[2] !== {1'b0, ts_of(r2)}) begin failures++; $display("FAIL both_third got=%h exp=%h", got_q[2], {1'b0, ts_of(r2)}); end
    end
    foreach (ev_q[i]) begin
      if (ev_q[i].wr) begin
        if (ev_q[i].data[11:8] != 4'h0) begin pb.push_back(ev_q[i].data[11:8]); prev_pop = 1; end
        else if (prev_pop) begin last_clr = ev_q[i].cyc; prev_pop = 0; end
      end else if (ev_q[i].addr == 8'h04 && last_clr >= 0) begin
        ngap++;
        checks++;
        if (ev_q[i].cyc - last_clr - 1 != S) begin
          failures++; $display("FAIL both_settle_gap got=%0d exp=%0d", ev_q[i].cyc - last_clr - 1, S);
        end
        last_clr = -1;
      end
    end
    checks++; if (ngap != 3) begin failures++; $display("FAIL both_gap_count got=%0d exp=3", ngap); end
    checks++;
    if (pb.size() != 3 || pb[0] !== 4'h4 || pb[1] !== 4'h1 || pb[2] !== 4'h4) begin
      failures++; $display("FAIL both_pop_bits got=%p exp=4,1,4", pb);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b;
    logic [55:0] snap;
    int n = 0;
    bit found = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    ts_ready_in = 1'b0;
    got_q.delete();
    rxq.push_back(a); txq.push_back(b);
    while (!ts_valid_out && n < 3 * P + 20) begin step(); n++; end
    ev_q.delete();
    snap = ts_data_out;
    checks++; if ({ts_dir_out, snap} !== {1'b0, ts_of(a)}) begin failures++; $display("FAIL bp_first got=%h exp=%h", {ts_dir_out, snap}, {1'b0, ts_of(a)}); end
    repeat (3 * P) step();
    checks++; if (ts_valid_out !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%0b exp=1", ts_valid_out); end
    checks++; if (ts_data_out !== ts_of(a)) begin failures++; $display("FAIL bp_data_stable got=%h exp=%h", ts_data_out, ts_of(a)); end
    checks++; if (count_rd04() != 0) begin failures++; $display("FAIL bp_no_poll got=%0d exp=0", count_rd04()); end
    checks++; if (count_pops() != 1) begin failures++; $display("FAIL bp_single_pop got=%0d exp=1", count_pops()); end
    ts_ready_in = 1'b1;
    ev_q.delete();
    for (int i = 0; i < P + 1 && !found; i++) begin step(); if (count_rd04() > 0) found = 1; end
    checks++; if (!found) begin failures++; $display("FAIL bp_resume_poll got=none exp=status read within %0d", P + 1); end
    n = 0;
    while (got_q.size() < 2 && n < 100) begin step(); n++; end
    checks++;
    if (got_q.size() != 2 || got_q[1] !== {1'b1, ts_of(b)}) begin
      failures++; $display("FAIL bp_second got_n=%0d exp=%h", got_q.size(), {1'b1, ts_of(b)});
    end
    repeat (10) step();
  endtask

  task automatic test_reset_pop();
    logic [63:0] c;
    int n = 0;
    c = {$urandom, $urandom};
    ts_ready_in = 1'b1;
    ctrl_base_in = 32'h1234_5F78;
    got_q.delete();
    rxq.push_back(c);
    while (!(wr_out && data_out[10]) && n < 3 * P + 20) begin step(); n++; end
    checks++; if (!(wr_out && data_out[10])) begin failures++; $display("FAIL rstpop_no_popset got=none exp=pop write"); end
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_out, rd_out, addr_out, data_out} !== '0) begin
      failures++; $display("FAIL rstpop_bus got=%0b%0b %h %h exp=0", wr_out, rd_out, addr_out, data_out);
    end
    checks++;
    if ({ts_valid_out, ts_dir_out, ts_data_out, busy_out} !== '0) begin
      failures++; $display("FAIL rstpop_stream got=%0b%0b %h %0b exp=0", ts_valid_out, ts_dir_out, ts_data_out, busy_out);
    end
    step(); step();
    ev_q.delete();
    rst = 1'b1;
    n = 0;
    while (ev_q.size() == 0 && n < 8) begin step(); n++; end
    checks++;
    if (ev_q.size() == 0 || !ev_q[0].wr || ev_q[0].addr !== 8'h00 || ev_q[0].data !== 32'h1234_5078) begin
      failures++; $display("FAIL rstpop_init got_n=%0d exp=write 00 12345078", ev_q.size());
    end
    n = 0;
    while (got_q.size() == 0 && n < 4 * P) begin step(); n++; end
    checks++;
    if (got_q.size() == 0 || got_q[0] !== {1'b0, ts_of(c)}) begin
      failures++; $display("FAIL rstpop_redrain got_n=%0d exp=%h", got_q.size(), {1'b0, ts_of(c)});
    end
    repeat (12) step();
  endtask

  task automatic test_enable_drop();
    logic [63:0] d;
    int n = 0;
    bit found = 0;
    d = {$urandom, $urandom};
    enable_in = 1'b1; ts_ready_in = 1'b1;
    got_q.delete(); ev_q.delete();
    txq.push_back(d);
    while (!(rd_out && addr_out == 8'h58) && n < 3 * P + 20) begin step(); n++; end
    enable_in = 1'b0;
    repeat (20) step();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, ts_of(d)}) begin
      failures++; $display("FAIL endrop_complete got_n=%0d exp=%h", got_q.size(), {1'b1, ts_of(d)});
    end
    checks++; if (count_pops() != 1) begin failures++; $display("FAIL endrop_pop got=%0d exp=1", count_pops()); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL endrop_busy got=%0b exp=0", busy_out); end
    ev_q.delete();
    repeat (3 * P) step();
    checks++; if (count_rd04() != 0) begin failures++; $display("FAIL endrop_no_poll got=%0d exp=0", count_rd04()); end
    enable_in = 1'b1;
    for (int i = 0; i < 4 && !found; i++) begin step(); if (count_rd04() > 0) found = 1; end
    checks++; if (!found) begin failures++; $display("FAIL endrop_resume got=none exp=status read"); end
  endtask

  task automatic test_random();
    int pushed = 0, n = 0;
    noise = 1;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      ts_ready_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0 && pushed < 40) begin
        if ($urandom_range(0, 1) == 0) rxq.push_back({$urandom, $urandom});
        else txq.push_back({$urandom, $urandom});
        pushed++;
      end
      step();
    end
    while (got_q.size() < pushed && n < 3000) begin
      ts_ready_in = 1'($urandom_range(0, 1));
      step(); n++;
    end
    ts_ready_in = 1'b1;
    repeat (4) step();
    noise = 0;
    checks++; if (got_q.size() != pushed) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), pushed); end
    checks++; if (exp_q.size() != got_q.size()) begin failures++; $display("FAIL rand_model_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    checks++; if (rxq.size() + txq.size() != 0) begin failures++; $display("FAIL rand_drained got=%0d exp=0", rxq.size() + txq.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_entry idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL bus_rules got=%0d violations exp=0", viol);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_poll();
    test_rx_entry();
    test_both();
    test_backpressure();
    test_reset_pop();
    test_enable_drop();
    test_random();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
